// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 size encodings, request struct.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} lsu_state_e;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_size_e;

  localparam int WORD_BYTES = 4;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } lsu_req_t;

  // funct3[1:0] picks the access size; illegal encodings (011/110/111) fall to word
  function automatic logic [1:0] size_of(input logic [2:0] f3);
    case ({1'b0, f3[1:0]})
      LB:      size_of = SZ_B;
      LH:      size_of = SZ_H;
      default: size_of = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for stores and extract/extend for loads.
// Low address bits are forced to the natural alignment of the access size.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off_in,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [1:0]            sz;
  logic [1:0]            off;
  logic [WORD_BYTES-1:0] strb;
  logic [7:0]            b;
  logic [15:0]           h;

  assign sz  = size_of(funct3);
  assign off = (sz == SZ_W) ? 2'b00 : (sz == SZ_H) ? {off_in[1], 1'b0} : off_in;

  for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
    assign strb[i] = (sz == SZ_B) ? (off == 2'(i)) :
                     (sz == SZ_H) ? (off[1] == 1'(i / 2)) : 1'b1;
    assign wdata_rep[8*i +: 8] = (sz == SZ_B) ? wdata[7:0] :
                                 (sz == SZ_H) ? wdata[8*(i%2) +: 8] : wdata[8*i +: 8];
  end

  assign wstrb = is_store ? strb : 4'b0000;

  assign b = rdata[{off, 3'b000} +: 8];
  assign h = rdata[{off[1], 4'b0000} +: 16];

  // funct3[2] selects zero-extension (BU/HU)
  always_comb begin
    rdata_ext = rdata;
    case (sz)
      SZ_B:    rdata_ext = funct3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_H:    rdata_ext = funct3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store stage: one word-bus transaction per request with timeout abort.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses complete with err, no bus request.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state, nxt;
  lsu_req_t          req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        cnt, cnt_inc;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              cap, tmo, trap;
  logic [3:0]        wstrb;
  logic [31:0]       wdata_rep, rdata_ext;

`ifdef MISALIGN_TRAP_EN
  logic [1:0] sz_in;
  assign sz_in = size_of(funct3);
  assign trap  = ((sz_in == SZ_H) && addr[0]) || ((sz_in == SZ_W) && (addr[1:0] != 2'b00));
`else
  assign trap  = 1'b0;
`endif

  lsu_align u_align (
    .is_store  (req_q.we),
    .funct3    (req_q.funct3),
    .off_in    (addr_q[1:0]),
    .wdata     (req_q.wdata),
    .rdata     (mem_rdata),
    .wstrb     (wstrb),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  assign cnt_inc = cnt + 8'd1;

  // A grant always wins over a timeout landing in the same cycle
  always_comb begin
    nxt = state;
    cap = 1'b0;
    tmo = 1'b0;
    case (state)
      IDLE: if (req_valid) nxt = trap ? DONE : REQ;
      REQ: begin
        if (mem_gnt) begin
          if (req_q.we) nxt = DONE;
          else if (mem_rvalid) begin
            nxt = DONE;
            cap = 1'b1;
          end else nxt = WAIT_R;
        end else if (cnt_inc == 8'(TIMEOUT_CYC)) begin
          nxt = DONE;
          tmo = 1'b1;
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          nxt = DONE;
          cap = 1'b1;
        end else if (cnt_inc == 8'(TIMEOUT_CYC)) begin
          nxt = DONE;
          tmo = 1'b1;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (req_valid) begin
          req_q   <= '{we: is_store, funct3: funct3, wdata: wdata};
          addr_q  <= addr;
          cnt     <= '0;
          rdata_q <= '0;
          err_q   <= trap;
        end
        REQ, WAIT_R: begin
          cnt <= cnt_inc;
          if (cap) rdata_q <= rdata_ext;
          if (tmo) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign done      = (state == DONE);
  assign err       = done & err_q;
  assign rdata     = done ? rdata_q : 32'b0;
  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req & req_q.we;
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wstrb = mem_req ? wstrb : 4'b0000;
  assign mem_wdata = wdata_rep;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected completions, monitor pops on done.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        done, err;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct { logic [31:0] rd; logic er; } exp_t;
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 with rdata %h, expected no completion", rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_rdata", rdata, e.rd);
        chk("done_err", {31'b0, err}, {31'b0, e.er});
      end
      if (prev_done) chk("done_pulse_width", {31'b0, prev_done}, 32'd0);
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: got req_ready=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // gdly>=100 means never grant; rdly=0 means rvalid with gnt
  task automatic txn(input string nm, input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int gdly, input int rdly,
                     input logic [31:0] eaddr, input logic [3:0] estrb, input logic [31:0] ewd,
                     input logic [31:0] erd, input logic eerr, input logic trap);
    exp_t e;
    wait_idle();
    e.rd = erd; e.er = eerr;
    sb.push_back(e);
    issue(st, f3, a, wd);
    if (trap) begin
      chk({nm, "_no_req"}, {31'b0, mem_req}, 32'd0);
      return;
    end
    chk({nm, "_req"}, {31'b0, mem_req}, 32'd1);
    chk({nm, "_addr"}, mem_addr, eaddr);
    chk({nm, "_we"}, {31'b0, mem_we}, {31'b0, st});
    chk({nm, "_wstrb"}, {28'b0, mem_wstrb}, {28'b0, estrb});
    chk({nm, "_wdata"}, mem_wdata, ewd);
    if (gdly >= 100) begin
      int hi = 0;
      while (mem_req && hi < 40) begin
        hi++;
        @(negedge clk);
      end
      chk({nm, "_req_cycles"}, hi, 32'd16);
      @(negedge clk);
      chk({nm, "_ready_after"}, {31'b0, req_ready}, 32'd1);
      return;
    end
    repeat (gdly) @(negedge clk);
    mem_gnt = 1'b1;
    if (!st && rdly == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
    end
    @(negedge clk);
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (!st && rdly > 0) begin
      repeat (rdly - 1) @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
      @(negedge clk);
      mem_rvalid = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b0; addr = '0; wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //   name     st    f3      addr          wdata         rdata         g  r  eaddr         strb     ewdata        erdata        err  trap
    txn("lw",    1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 2, 32'h100, 4'b0000, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
    txn("lb",    1'b0, 3'b000, 32'h103, 32'h0,        32'h80112233, 0, 1, 32'h100, 4'b0000, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0);
    txn("lbu",   1'b0, 3'b100, 32'h103, 32'h0,        32'h80112233, 0, 0, 32'h100, 4'b0000, 32'h0,        32'h00000080, 1'b0, 1'b0);
    txn("lhu",   1'b0, 3'b101, 32'h102, 32'h0,        32'h80112233, 1, 1, 32'h100, 4'b0000, 32'h0,        32'h00008011, 1'b0, 1'b0);
    txn("lh",    1'b0, 3'b001, 32'h102, 32'h0,        32'h80112233, 0, 3, 32'h100, 4'b0000, 32'h0,        32'hFFFF8011, 1'b0, 1'b0);
    txn("lh_lo", 1'b0, 3'b001, 32'h100, 32'h0,        32'h80112233, 0, 1, 32'h100, 4'b0000, 32'h0,        32'h00002233, 1'b0, 1'b0);
    txn("sh",    1'b1, 3'b001, 32'h102, 32'hAAAA1234, 32'h0,        2, 0, 32'h100, 4'b1100, 32'h12341234, 32'h0,        1'b0, 1'b0);
    txn("sb",    1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0,        0, 0, 32'h100, 4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0);
    txn("sw",    1'b1, 3'b010, 32'h104, 32'h01234567, 32'h0,        1, 0, 32'h104, 4'b1111, 32'h01234567, 32'h0,        1'b0, 1'b0);
    txn("ill_w", 1'b0, 3'b111, 32'h108, 32'h0,        32'hCAFEF00D, 0, 1, 32'h108, 4'b0000, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0);
    txn("tmo",   1'b0, 3'b010, 32'h200, 32'h0,        32'h0,      100, 0, 32'h200, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0);
`ifdef MISALIGN_TRAP_EN
    txn("lw_mis",1'b0, 3'b010, 32'h101, 32'h0,        32'h11223344, 0, 1, 32'h100, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b1);
`else
    txn("lw_mis",1'b0, 3'b010, 32'h101, 32'h0,        32'h11223344, 0, 1, 32'h100, 4'b0000, 32'h0,        32'h11223344, 1'b0, 1'b0);
`endif

    // Reset pulled in WAIT_R: nothing may complete, late rvalid is ignored
    wait_idle();
    issue(1'b0, 3'b010, 32'h300, 32'h0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_err", {31'b0, err}, 32'd0);
    chk("midrst_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55555555;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    txn("lw_post",1'b0,3'b010, 32'h304, 32'h0,        32'h0BADC0DE, 0, 1, 32'h304, 4'b0000, 32'h0,        32'h0BADC0DE, 1'b0, 1'b0);

    begin
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (sb.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL drain: got %0d pending completions expected 0", sb.size());
      end
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
